bit_scan_encoder: RTL and testbench
===================================

BIT_SCAN_ENCODER -- requirements
Module: bit_scan_encoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the request vector width; legal values are 2..32.
REQ-002 SHALL have parameter IDXW, default 3, the index width; it SHALL equal clog2(WIDTH).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  upstream offers in_data.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 in_data  input  WIDTH  request vector to encode; a 1 bit is a set request.
REQ-008 out_valid  output  1  out_idx, out_zero and out_last are valid.
REQ-009 out_ready  input  1  downstream takes the current beat.
REQ-010 out_idx  output  IDXW  bit position of the current set bit.
REQ-011 out_last  output  1  current beat is the final beat for the captured vector.
REQ-012 out_zero  output  1  the captured vector was all zeros.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and SCAN.
REQ-014 In IDLE: in_ready=1 and out_valid=0.
REQ-015 In SCAN: in_ready=0 and out_valid=1.
REQ-016 Acceptance: in IDLE with in_valid=1, the edge SHALL load in_data into an internal pending register and move to SCAN; out_valid SHALL rise the next cycle (latency 1).
REQ-017 Priority is MSB-first: out_idx = the highest set bit position in pending; the encoder SHALL be combinational on pending and implemented with casez/wildcard matching.
REQ-018 out_last = 1 when pending holds exactly one set bit, or when out_zero=1.
REQ-019 Beat transfer: on out_valid&&out_ready, the bit at out_idx SHALL be cleared in pending; if out_last=1, the FSM SHALL return to IDLE.
REQ-020 Zero vector: pending==0 on entry to SCAN SHALL produce exactly one beat with out_zero=1, out_idx=0 and out_last=1.
REQ-021 out_zero SHALL be 0 on every beat of a non-zero vector.
REQ-022 Backpressure: while out_valid=1 and out_ready=0, out_idx, out_last, out_zero and pending SHALL hold stable.
REQ-023 Beat count per non-zero vector SHALL equal popcount(in_data); beats SHALL be emitted in strictly descending index order.
REQ-024 Throughput: with out_ready held high, a vector of N set bits occupies N SCAN cycles plus 1 IDLE cycle; back-to-back vectors SHALL have no gap other than that IDLE cycle.
REQ-025 in_data changes while the FSM is in SCAN SHALL have no effect.
REQ-026 All-ones vector: for WIDTH=8, SHALL emit idx 7,6,...,0 and assert out_last only on idx 0.
REQ-027 In IDLE, out_idx, out_last and out_zero SHALL be driven to 0.

Reset
REQ-028 rst_n=0 sampled at a rising clk edge SHALL force IDLE and pending=0, giving in_ready=1, out_valid=0, out_idx=0, out_last=0 and out_zero=0 from the following cycle.
REQ-029 Reset asserted mid-SCAN SHALL abandon the vector with no further beats; the first post-reset acceptance SHALL behave as REQ-016.
REQ-030 The block SHALL contain no asynchronous reset path.

Verification
REQ-031 Single bit: in_data=8'b0010_0000 accepted, out_ready=1 -> next cycle one beat idx=5, last=1, zero=0, then IDLE.
REQ-032 Multi-bit: in_data=8'b1000_0101, out_ready=1 -> beats idx=7 (last 0), idx=2 (last 0), idx=0 (last 1) on consecutive cycles.
REQ-033 Zero: in_data=8'h00 -> exactly one beat with zero=1, idx=0, last=1.
REQ-034 Backpressure: in_data=8'b0000_0011, out_ready low for 3 cycles -> idx=1 held stable for 3 cycles; after out_ready goes high, beats idx=1 then idx=0 (last 1).
REQ-035 Reset mid-SCAN: in_data=8'hFF, reset after 2 beats (idx 7, 6) -> out_valid=0 and in_ready=1 the cycle after reset; next in_data=8'h01 -> single beat idx=0, last=1.
REQ-036 Random: 1000 random vectors with random out_ready -> scoreboard checks beat count = popcount, descending order, last flag on final beat only.

Source files
------------

// File: rtl/bit_scan_encoder.sv
// Captures a request vector and replays its set bits as an MSB-first stream of
// index beats under a valid/ready handshake. An all-zero vector yields one flagged beat.
module bit_scan_encoder #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             out_zero
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] pending, pending_d;
  logic [31:0]      scan_vec;
  logic [IDXW-1:0]  enc_idx;
  logic             enc_zero;
  logic             enc_last;

  // Highest set bit of pending; the vector is widened to 32 bits so one table
  // serves every legal WIDTH, and patterns above WIDTH simply never match.
  always_comb begin
    scan_vec = 32'(pending);
    enc_idx  = '0;
    casez (scan_vec)
      {1'b1, 31'b?}:         enc_idx = IDXW'(31);
      {1'b0, 1'b1, 30'b?}:   enc_idx = IDXW'(30);
      {2'b0, 1'b1, 29'b?}:   enc_idx = IDXW'(29);
      {3'b0, 1'b1, 28'b?}:   enc_idx = IDXW'(28);
      {4'b0, 1'b1, 27'b?}:   enc_idx = IDXW'(27);
      {5'b0, 1'b1, 26'b?}:   enc_idx = IDXW'(26);
      {6'b0, 1'b1, 25'b?}:   enc_idx = IDXW'(25);
      {7'b0, 1'b1, 24'b?}:   enc_idx = IDXW'(24);
      {8'b0, 1'b1, 23'b?}:   enc_idx = IDXW'(23);
      {9'b0, 1'b1, 22'b?}:   enc_idx = IDXW'(22);
      {10'b0, 1'b1, 21'b?}:  enc_idx = IDXW'(21);
      {11'b0, 1'b1, 20'b?}:  enc_idx = IDXW'(20);
      {12'b0, 1'b1, 19'b?}:  enc_idx = IDXW'(19);
      {13'b0, 1'b1, 18'b?}:  enc_idx = IDXW'(18);
      {14'b0, 1'b1, 17'b?}:  enc_idx = IDXW'(17);
      {15'b0, 1'b1, 16'b?}:  enc_idx = IDXW'(16);
      {16'b0, 1'b1, 15'b?}:  enc_idx = IDXW'(15);
      {17'b0, 1'b1, 14'b?}:  enc_idx = IDXW'(14);
      {18'b0, 1'b1, 13'b?}:  enc_idx = IDXW'(13);
      {19'b0, 1'b1, 12'b?}:  enc_idx = IDXW'(12);
      {20'b0, 1'b1, 11'b?}:  enc_idx = IDXW'(11);
      {21'b0, 1'b1, 10'b?}:  enc_idx = IDXW'(10);
      {22'b0, 1'b1, 9'b?}:   enc_idx = IDXW'(9);
      {23'b0, 1'b1, 8'b?}:   enc_idx = IDXW'(8);
      {24'b0, 1'b1, 7'b?}:   enc_idx = IDXW'(7);
      {25'b0, 1'b1, 6'b?}:   enc_idx = IDXW'(6);
      {26'b0, 1'b1, 5'b?}:   enc_idx = IDXW'(5);
      {27'b0, 1'b1, 4'b?}:   enc_idx = IDXW'(4);
      {28'b0, 1'b1, 3'b?}:   enc_idx = IDXW'(3);
      {29'b0, 1'b1, 2'b?}:   enc_idx = IDXW'(2);
      {30'b0, 1'b1, 1'b?}:   enc_idx = IDXW'(1);
      {31'b0, 1'b1}:         enc_idx = IDXW'(0);
      default:               enc_idx = '0;
    endcase
  end

  assign enc_zero = (pending == '0);
  assign enc_last = enc_zero || ((pending & (pending - 1'b1)) == '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state;
    pending_d = pending;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pending_d = in_data;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          pending_d = pending & ~(WIDTH'(1) << enc_idx);
          if (enc_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers update with non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_d;
      pending <= pending_d;
    end
  end

  assign out_idx  = (state == SCAN) ? enc_idx : '0;
  assign out_last = (state == SCAN) && enc_last;
  assign out_zero = (state == SCAN) && enc_zero;

endmodule

// File: tb/tb_bit_scan_encoder.sv
// Scoreboard bench for bit_scan_encoder: the driver pushes the beats each accepted
// vector should produce; a negedge monitor pops and compares every transferred beat.
module tb_bit_scan_encoder;

  localparam int WIDTH = 8;
  localparam int IDXW  = 3;

  typedef struct {
    int idx;
    bit last;
    bit zero;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;
  logic             out_zero;

  int    checks = 0;
  int    failures = 0;
  int    beats_seen = 0;
  int    exp_total = 0;
  int    cyc = 0;
  bit    rand_ready = 1'b0;
  beat_t exp_q[$];

  bit              prev_stall = 1'b0;
  logic [IDXW+1:0] held;
  beat_t           e;

  bit_scan_encoder #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_last(out_last), .out_zero(out_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: one beat per set bit, highest position first; a zero vector gives one flagged beat.
  task automatic push_expected(input logic [WIDTH-1:0] v);
    int remaining;
    beat_t b;
    if (v == '0) begin
      b.idx = 0; b.last = 1'b1; b.zero = 1'b1;
      exp_q.push_back(b);
      exp_total++;
    end else begin
      remaining = $countones(v);
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (v[i]) begin
          remaining--;
          b.idx = i; b.last = (remaining == 0); b.zero = 1'b0;
          exp_q.push_back(b);
          exp_total++;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns just after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] v);
    bit accepted = 1'b0;
    in_data  = v;
    in_valid = 1'b1;
    for (int n = 0; n < 1000 && !accepted; n++) begin
      @(negedge clk);
      if (in_ready) begin
        push_expected(v);
        accepted = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    if (!accepted) check("send_timeout", 32'(accepted), 32'd1);
  endtask

  task automatic beat_now(input string name, input int idx, input bit last, input bit zero);
    @(negedge clk);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_idx"}, 32'(out_idx), 32'(idx));
    check({name, "_last"}, 32'(out_last), 32'(last));
    check({name, "_zero"}, 32'(out_zero), 32'(zero));
  endtask

  task automatic idle_now(input string name);
    @(negedge clk);
    check({name, "_out_valid"}, 32'(out_valid), 32'd0);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: handshake sanity, stall stability, and scoreboard pop on each transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      check("in_ready_xor_valid", 32'(in_ready), 32'(!out_valid));
      if (!out_valid) begin
        check("idle_outputs", 32'({out_idx, out_last, out_zero}), 32'd0);
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("stall_hold", 32'({out_idx, out_last, out_zero}), 32'(held));
        if (out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat: got idx %0d last %0b zero %0b expected no beat",
                     out_idx, out_last, out_zero);
          end else begin
            e = exp_q.pop_front();
            beats_seen++;
            if (out_idx != IDXW'(e.idx) || out_last != e.last || out_zero != e.zero) begin
              failures++;
              $display("FAIL sb_beat: got idx %0d last %0b zero %0b expected idx %0d last %0b zero %0b",
                       out_idx, out_last, out_zero, e.idx, e.last, e.zero);
            end
          end
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          held = {out_idx, out_last, out_zero};
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    logic [WIDTH-1:0] v;

    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", 32'({out_idx, out_last, out_zero}), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single bit
    out_ready = 1'b1;
    send(8'b0010_0000);
    beat_now("single", 5, 1'b1, 1'b0);
    idle_now("single_done");
    step();

    // Multi-bit, consecutive beats
    send(8'b1000_0101);
    beat_now("multi0", 7, 1'b0, 1'b0);
    beat_now("multi1", 2, 1'b0, 1'b0);
    beat_now("multi2", 0, 1'b1, 1'b0);
    idle_now("multi_done");
    step();

    // Zero vector
    send(8'h00);
    beat_now("zero", 0, 1'b1, 1'b1);
    idle_now("zero_done");
    step();

    // All ones
    send(8'hFF);
    for (int i = 7; i >= 0; i--) beat_now("ones", i, (i == 0), 1'b0);
    idle_now("ones_done");
    step();

    // Backpressure, with in_data scrambled while scanning
    out_ready = 1'b0;
    send(8'b0000_0011);
    in_data = 8'hA5;
    beat_now("bp_hold0", 1, 1'b0, 1'b0);
    beat_now("bp_hold1", 1, 1'b0, 1'b0);
    beat_now("bp_hold2", 1, 1'b0, 1'b0);
    step();
    out_ready = 1'b1;
    beat_now("bp_rel0", 1, 1'b0, 1'b0);
    beat_now("bp_rel1", 0, 1'b1, 1'b0);
    idle_now("bp_done");
    step();

    // Back-to-back throughput: N beats + 1 idle cycle between acceptances
    send(8'b1010_0000);
    t0 = cyc;
    send(8'b0000_0001);
    check("b2b_gap_cycles", 32'(cyc - t0), 32'd3);
    beat_now("b2b_second", 0, 1'b1, 1'b0);
    step();

    // Reset mid-scan after two beats
    send(8'hFF);
    beat_now("rst_mid0", 7, 1'b0, 1'b0);
    beat_now("rst_mid1", 6, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    step();
    rst_n = 1'b1;
    idle_now("post_rst");
    step();
    send(8'h01);
    beat_now("post_rst_beat", 0, 1'b1, 1'b0);
    step();

    // Random vectors, random backpressure, random idle gaps
    exp_total  = 0;
    beats_seen = 0;
    rand_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 7))
        0:       v = '0;
        1:       v = '1;
        2:       v = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
        default: v = WIDTH'($urandom);
      endcase
      repeat ($urandom_range(0, 2)) step();
      send(v);
      in_data = WIDTH'($urandom);
    end
    for (int n = 0; n < 2000 && exp_q.size() != 0; n++) step();
    rand_ready = 1'b0;
    step();
    out_ready = 1'b1;
    repeat (3) step();
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("random_beat_total", 32'(beats_seen), 32'(exp_total));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
